// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the memory request/response channel, the redirect input, the Core
// stall input and the instruction output presented to the Core IF latch.
//   master : the fetch unit (drives imem request and code outputs)
//   slave  : the environment (instruction memory + Core)
interface instr_fetch_if;
   logic        imem_req_valid;
   logic [23:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [23:0] redirect_pc;
   logic        stall;
   logic [31:0] code;
   logic [23:0] code_pc;
   logic        code_valid;

   modport master (
      output imem_req_valid, imem_req_addr, code, code_pc, code_valid,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, code, code_pc, code_valid,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect, redirect_pc, stall
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end for the five-stage Core.
// Owns the fetch PC, issues in-order reads to instruction memory, buffers
// returned words with their PCs in a prefetch FIFO and presents the FIFO head
// to the Core. A redirect flushes the FIFO and marks every request still in
// flight as stale so its response is dropped on arrival.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : synchronous active-low reset
//   bus    : instr_fetch_if.master (imem req/rsp, redirect, stall, code out)
module instr_fetch #(
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [23:0] RESET_PC        = 24'h000000,
   parameter int          PC_STEP         = 4
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [23:0]   fetch_pc_q, fetch_pc_d;
   logic          started_q;
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [23:0]   fifo_pc_q   [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
   // PCs of issued-but-unanswered requests, oldest first
   logic [23:0]   tag_q [MAX_OUTSTANDING];
   logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

   logic          req_valid, req_fire, rsp_take, fifo_push, fifo_pop, head_valid;

   // Tag queue depth need not be a power of two, so wrap explicitly.
   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
   endfunction

   always_comb begin
      // Credit rule: never have more requests in flight than free FIFO slots,
      // so a response can always be written without back-pressure.
      req_valid = reset && started_q && !bus.redirect
                  && (int'(outst_q) < MAX_OUTSTANDING)
                  && (int'(outst_q) + int'(count_q) < FIFO_DEPTH);
      req_fire  = req_valid && bus.imem_req_ready;
      // Responses with nothing outstanding are spurious and ignored.
      rsp_take  = bus.imem_rsp_valid && (outst_q != '0);
      head_valid = (count_q != '0);
      fifo_pop  = head_valid && !bus.stall;
      fifo_push = rsp_take && (discard_q == '0) && !bus.redirect;

      outst_d  = outst_q + OW'(req_fire) - OW'(rsp_take);
      // Tags stay aligned across redirects: every response pops one tag.
      tag_wr_d = req_fire ? tag_inc(tag_wr_q) : tag_wr_q;
      tag_rd_d = rsp_take ? tag_inc(tag_rd_q) : tag_rd_q;

      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         // Everything still in flight after this cycle is stale.
         discard_d  = outst_d;
      end else begin
         fetch_pc_d = req_fire ? fetch_pc_q + 24'(PC_STEP) : fetch_pc_q;
         rd_ptr_d   = fifo_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
         wr_ptr_d   = fifo_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
         count_d    = count_q + CW'(fifo_push) - CW'(fifo_pop);
         discard_d  = (rsp_take && discard_q != '0) ? discard_q - OW'(1) : discard_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         started_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
      end else begin
         // Holds off the first request until the cycle after reset release.
         started_q  <= 1'b1;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
         if (req_fire) tag_q[tag_wr_q] <= fetch_pc_q;
         if (fifo_push) begin
            fifo_data_q[wr_ptr_q] <= bus.imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
         end
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.code_valid     = head_valid;
   // Bubble is all zeros so the Core latch sees a clean NOP-like value.
   assign bus.code           = head_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
   assign bus.code_pc        = head_valid ? fifo_pc_q[rd_ptr_q]   : 24'h0;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based reference model plus an
// in-order memory model with configurable latency, directed scenarios and a
// randomized run.
module tb_instr_fetch;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if bus ();

   instr_fetch #(
      .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(24'h000000), .PC_STEP(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat_min = 1;
   int lat_max = 1;
   int last_due = 0;
   bit spurious_en = 1'b0;

   // memory model
   logic [23:0] mq_addr[$];
   int          mq_due[$];
   logic [23:0] hs_q[$];

   // reference model
   logic [23:0] m_pc = 24'h000000;
   logic [23:0] m_infl[$];
   logic [55:0] m_fifo[$];
   int          m_disc = 0;
   bit          m_started = 1'b0;

   function automatic logic [31:0] memword(input logic [23:0] a);
      return {a[9:2], a} ^ 32'hC0DE_1234;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic cycle();
      bit          rv, fire, rsp, pop, from_mem;
      logic [23:0] tag;
      logic [55:0] head;
      int          lat;
      from_mem = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
      if (from_mem) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = memword(mq_addr[0]);
      end else if (spurious_en && mq_addr.size() == 0 && $urandom_range(9, 0) == 0) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = $urandom;
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0;
      end
      #4;
      rv = reset && m_started && !bus.redirect && (m_infl.size() < MAXO)
           && ((m_infl.size() + m_fifo.size()) < DEPTH);
      head = (m_fifo.size() > 0) ? m_fifo[0] : 56'h0;
      check("req_valid", bus.imem_req_valid, rv);
      if (rv) check("req_addr", bus.imem_req_addr, m_pc);
      check("code_valid", bus.code_valid, m_fifo.size() > 0);
      check("code", bus.code, head[55:24]);
      check("code_pc", bus.code_pc, head[23:0]);
      check("inv_outstanding", int'(dut.outst_q) <= MAXO, 1'b1);
      check("inv_credit", int'(dut.count_q) + int'(dut.outst_q) <= DEPTH, 1'b1);
      check("inv_discard", dut.discard_q <= dut.outst_q, 1'b1);

      // memory side
      if (from_mem) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
         lat = $urandom_range(lat_max, lat_min);
         last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         mq_addr.push_back(bus.imem_req_addr);
         mq_due.push_back(last_due);
         hs_q.push_back(bus.imem_req_addr);
      end

      // reference model
      if (!reset) begin
         m_pc = 24'h000000;
         m_infl.delete();
         m_fifo.delete();
         m_disc = 0;
         m_started = 1'b0;
         mq_addr.delete();
         mq_due.delete();
         last_due = cyc;
      end else begin
         fire = rv && bus.imem_req_ready;
         rsp  = bus.imem_rsp_valid && (m_infl.size() > 0);
         pop  = (m_fifo.size() > 0) && !bus.stall;
         tag  = 24'h0;
         m_started = 1'b1;
         if (rsp) tag = m_infl.pop_front();
         if (bus.redirect) begin
            m_fifo.delete();
            m_pc   = bus.redirect_pc;
            m_disc = m_infl.size();
         end else begin
            if (pop) void'(m_fifo.pop_front());
            if (rsp) begin
               if (m_disc > 0) m_disc--;
               else m_fifo.push_back({bus.imem_rsp_data, tag});
            end
            if (fire) begin
               m_infl.push_back(m_pc);
               m_pc = m_pc + 24'd4;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int          first_cv;
      logic [23:0] first_pc;
      logic [31:0] first_code;
      logic [23:0] pcs[4];
      bit          found;

      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.redirect       = 1'b0;
      bus.redirect_pc    = 24'h0;
      bus.stall          = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_valid", bus.imem_req_valid, 1'b0);
      check("rst_code_valid", bus.code_valid, 1'b0);
      check("rst_code", bus.code, 32'h0);
      check("rst_code_pc", bus.code_pc, 24'h0);
      cycle();

      // sequential fetch, 1-cycle memory
      reset = 1'b1;
      hs_q.delete();
      first_cv = -1;
      first_pc = 24'hFFFFFF;
      first_code = 32'h0;
      for (int i = 0; i < 12; i++) begin
         if (bus.code_valid && first_cv < 0) begin
            first_cv = i;
            first_pc = bus.code_pc;
            first_code = bus.code;
         end
         cycle();
      end
      check("first_code_valid_cycle", first_cv, 3);
      check("first_code_pc", first_pc, 24'h000000);
      check("first_code", first_code, memword(24'h000000));
      check("seq_count", hs_q.size() >= 3, 1'b1);
      if (hs_q.size() >= 3) begin
         check("seq_addr0", hs_q[0], 24'h000000);
         check("seq_addr1", hs_q[1], 24'h000004);
         check("seq_addr2", hs_q[2], 24'h000008);
      end

      // stall fills the FIFO, then drains in order
      bus.stall = 1'b1;
      repeat (10) cycle();
      #1;
      check("stall_req_valid", bus.imem_req_valid, 1'b0);
      check("stall_fifo_count", dut.count_q, DEPTH);
      check("stall_code_valid", bus.code_valid, 1'b1);
      bus.stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pcs[i] = bus.code_pc;
         check("drain_valid", bus.code_valid, 1'b1);
         cycle();
      end
      for (int i = 0; i < 3; i++) check("drain_order", pcs[i+1], pcs[i] + 24'd4);

      // redirect with two requests in flight
      lat_min = 3; lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_infl.size() == MAXO) begin found = 1'b1; break; end
         cycle();
      end
      check("redir_setup", found, 1'b1);
      bus.redirect = 1'b1; bus.redirect_pc = 24'h000100;
      cycle();
      bus.redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.code_valid) begin found = 1'b1; break; end
         cycle();
      end
      check("redir_wait", found, 1'b1);
      check("redir_code_pc", bus.code_pc, 24'h000100);
      check("redir_code", bus.code, memword(24'h000100));

      // redirect while a response arrives and credits are exhausted
      bus.stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_fifo.size() == 2 && m_infl.size() == 2 && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            found = 1'b1; break;
         end
         cycle();
      end
      check("rsp_redir_setup", found, 1'b1);
      bus.redirect = 1'b1; bus.redirect_pc = 24'h000200;
      #1;
      check("rsp_redir_req_valid", bus.imem_req_valid, 1'b0);
      cycle();
      bus.redirect = 1'b0;
      check("rsp_redir_code_valid", bus.code_valid, 1'b0);
      check("rsp_redir_fifo_count", dut.count_q, 0);
      check("rsp_redir_discard", dut.discard_q, 1);

      // PC wrap
      bus.stall = 1'b0;
      lat_min = 1; lat_max = 1;
      bus.redirect = 1'b1; bus.redirect_pc = 24'hFFFFFC;
      cycle();
      bus.redirect = 1'b0;
      hs_q.delete();
      repeat (8) cycle();
      check("wrap_count", hs_q.size() >= 2, 1'b1);
      if (hs_q.size() >= 2) begin
         check("wrap_addr0", hs_q[0], 24'hFFFFFC);
         check("wrap_addr1", hs_q[1], 24'h000000);
      end

      // reset with a full FIFO
      bus.stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (m_fifo.size() == DEPTH) begin found = 1'b1; break; end
         cycle();
      end
      check("midrst_setup", found, 1'b1);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      check("midrst_code_valid", bus.code_valid, 1'b0);
      check("midrst_code", bus.code, 32'h0);
      check("midrst_code_pc", bus.code_pc, 24'h0);
      check("midrst_req_valid", bus.imem_req_valid, 1'b0);
      hs_q.delete();
      bus.stall = 1'b0;
      repeat (6) cycle();
      check("midrst_restart_count", hs_q.size() >= 1, 1'b1);
      if (hs_q.size() >= 1) check("midrst_restart_addr", hs_q[0], 24'h000000);

      // randomized run
      spurious_en = 1'b1;
      lat_min = 1; lat_max = 4;
      repeat (3000) begin
         logic [31:0] r;
         r = $urandom;
         bus.imem_req_ready = ($urandom_range(9, 0) < 7);
         bus.stall          = ($urandom_range(9, 0) < 3);
         bus.redirect       = ($urandom_range(19, 0) == 0);
         bus.redirect_pc    = {r[23:2], 2'b00};
         reset              = !($urandom_range(299, 0) == 0);
         cycle();
      end
      reset = 1'b1;
      bus.redirect = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
